// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared constants and FSM state type for the binary32 divider
package fpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [31:0]       QNAN = 32'h7FC0_0000;
  localparam logic signed [9:0] BIAS = 10'sd127;
  localparam logic [4:0]        ITER = 5'd25;

  // Bit positions inside the {NV, DZ, OF, UF, NX} flag vector
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

endpackage

// File: rtl/fdiv_special.sv
// rtl/fdiv_special.sv - operand classifier and special-case result select
module fdiv_special
  import fpu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_special,
  output logic [31:0] o_result,
  output logic [4:0]  o_flags
);

  logic w_sign;
  logic w_a_zero, w_a_inf, w_a_nan;
  logic w_b_zero, w_b_inf, w_b_nan;

  assign w_sign   = i_a[31] ^ i_b[31];
  assign w_a_zero = (i_a[30:23] == 8'h00);
  assign w_a_inf  = (i_a[30:23] == 8'hFF) && (i_a[22:0] == 23'd0);
  assign w_a_nan  = (i_a[30:23] == 8'hFF) && (i_a[22:0] != 23'd0);
  assign w_b_zero = (i_b[30:23] == 8'h00);
  assign w_b_inf  = (i_b[30:23] == 8'hFF) && (i_b[22:0] == 23'd0);
  assign w_b_nan  = (i_b[30:23] == 8'hFF) && (i_b[22:0] != 23'd0);

  always_comb begin
    o_special = 1'b1;
    o_result  = 32'd0;
    o_flags   = 5'd0;
    if (w_a_nan) begin
      o_result = i_a;
    end else if (w_b_nan) begin
      o_result = i_b;
    end else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
      o_result         = QNAN;
      o_flags[FLAG_NV] = 1'b1;
    end else if (w_b_zero && !w_a_inf) begin
      o_result         = {w_sign, 8'hFF, 23'd0};
      o_flags[FLAG_DZ] = 1'b1;
    end else if (w_a_inf) begin
      o_result = {w_sign, 8'hFF, 23'd0};
    end else if (w_b_inf || w_a_zero) begin
      o_result = {w_sign, 31'd0};
    end else begin
      o_special = 1'b0;
    end
  end

endmodule

// File: rtl/fdiv_seq.sv
// rtl/fdiv_seq.sv - sequential restoring binary32 divider, one quotient bit per cycle
module fdiv_seq
  import fpu_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        FLUSH,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] IN1,
  input  logic [31:0] IN2,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] OUT,
  output logic [4:0]  FLAGS
);

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [31:0]        r_out;
  logic [4:0]         r_flags;
  logic [4:0]         r_cnt;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [24:0]        r_rem;
  logic [23:0]        r_m2;
  logic [24:0]        r_q;

  logic               w_special;
  logic [31:0]        w_sp_result;
  logic [4:0]         w_sp_flags;
  logic [25:0]        w_trial;
  logic               w_bit;
  logic [24:0]        w_new;
  logic [22:0]        w_frac;
  logic signed [9:0]  w_exp;
  logic               w_sticky;

  fdiv_special u_special (
    .i_a       (IN1),
    .i_b       (IN2),
    .o_special (w_special),
    .o_result  (w_sp_result),
    .o_flags   (w_sp_flags)
  );

  // Single shared subtractor: the sign of the trial difference is the quotient bit
  assign w_trial = {1'b0, r_rem} - {2'b00, r_m2};
  assign w_bit   = ~w_trial[25];
  assign w_new   = w_bit ? w_trial[24:0] : r_rem;

  assign w_frac   = r_q[24] ? r_q[23:1] : r_q[22:0];
  assign w_exp    = r_exp + (r_q[24] ? BIAS : (BIAS - 10'sd1));
  assign w_sticky = (r_q[24] & r_q[0]) | (|r_rem);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= 32'd0;
      r_flags     <= 5'd0;
      r_cnt       <= 5'd0;
      r_sign      <= 1'b0;
      r_exp       <= 10'sd0;
      r_rem       <= 25'd0;
      r_m2        <= 24'd0;
      r_q         <= 25'd0;
    end else if (FLUSH) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_cnt       <= 5'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (IN_VALID) begin
            r_in_ready <= 1'b0;
            r_sign     <= IN1[31] ^ IN2[31];
            r_cnt      <= 5'd0;
            if (w_special) begin
              r_out       <= w_sp_result;
              r_flags     <= w_sp_flags;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_exp   <= $signed({2'b00, IN1[30:23]}) - $signed({2'b00, IN2[30:23]});
              r_rem   <= {2'b01, IN1[22:0]};
              r_m2    <= {1'b1, IN2[22:0]};
              r_q     <= 25'd0;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_q   <= {r_q[23:0], w_bit};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == ITER - 5'd1) begin
            r_rem   <= w_new;
            r_state <= NORM;
          end else begin
            r_rem <= {w_new[23:0], 1'b0};
          end
        end
        NORM: begin
          r_flags <= 5'd0;
          if (w_exp >= 10'sd255) begin
            r_out            <= {r_sign, 8'hFF, 23'd0};
            r_flags[FLAG_OF] <= 1'b1;
            r_flags[FLAG_NX] <= 1'b1;
          end else if (w_exp <= 10'sd0) begin
            r_out            <= {r_sign, 31'd0};
            r_flags[FLAG_UF] <= 1'b1;
            r_flags[FLAG_NX] <= 1'b1;
          end else begin
            r_out            <= {r_sign, w_exp[7:0], w_frac};
            r_flags[FLAG_NX] <= w_sticky;
          end
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (OUT_READY) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_out_valid;
  assign OUT       = r_out;
  assign FLAGS     = r_flags;

endmodule

// File: tb/tb_fdiv_seq.sv
// tb/tb_fdiv_seq.sv - randomized self-checking bench for fdiv_seq against an arithmetic model
module tb_fdiv_seq;

  logic        CLK = 1'b0;
  logic        RST;
  logic        FLUSH;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN1;
  logic [31:0] IN2;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT;
  logic [4:0]  FLAGS;

  int n_checks = 0;
  int n_pass   = 0;

  fdiv_seq dut (
    .CLK       (CLK),
    .RST       (RST),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN1       (IN1),
    .IN2       (IN2),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT       (OUT),
    .FLAGS     (FLAGS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Quotient from integer division of the scaled mantissas, then binary32 packing
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] f,
                                  output bit sp);
    bit s, an, ai, az, bn, bi, bz, inexact;
    int ea, eb, e;
    longint unsigned ma, mb, q, rm, mant;
    logic [31:0] ev;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    an = (ea == 255) && (a[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    az = (ea == 0);
    bn = (eb == 255) && (b[22:0] != 0);
    bi = (eb == 255) && (b[22:0] == 0);
    bz = (eb == 0);
    sp = 1;
    f  = 5'b00000;
    r  = 32'd0;
    if (an) r = a;
    else if (bn) r = b;
    else if ((az && bz) || (ai && bi)) begin r = 32'h7FC00000; f = 5'b10000; end
    else if (bz && !ai) begin r = {s, 8'hFF, 23'd0}; f = 5'b01000; end
    else if (ai) r = {s, 8'hFF, 23'd0};
    else if (bi || az) r = {s, 31'd0};
    else begin
      sp = 0;
      ma = 64'h800000 + longint'(a[22:0]);
      mb = 64'h800000 + longint'(b[22:0]);
      q  = (ma << 24) / mb;
      rm = (ma << 24) % mb;
      if (q >= 64'h1000000) begin
        mant    = q >> 1;
        inexact = (q % 2 != 0) || (rm != 0);
        e       = ea - eb + 127;
      end else begin
        mant    = q;
        inexact = (rm != 0);
        e       = ea - eb + 126;
      end
      ev = e;
      if (e >= 255) begin r = {s, 8'hFF, 23'd0}; f = 5'b00101; end
      else if (e <= 0) begin r = {s, 31'd0}; f = 5'b00011; end
      else begin r = {s, ev[7:0], mant[22:0]}; f = {4'b0000, inexact}; end
    end
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 11);
    if (k == 0) v[30:23] = 8'h00;
    else if (k == 1) v[30:23] = 8'hFF;
    else if (k == 2) begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
    else if (k == 3) v[30:23] = 8'($urandom_range(100, 154));
    return v;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!IN_READY && n < 100) begin @(posedge CLK); #1; n++; end
    check({tag, "_ready"}, 32'(IN_READY), 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall, input string tag);
    logic [31:0] er;
    logic [4:0]  ef;
    bit          sp;
    int          lat;
    logic [31:0] held_out;
    logic [4:0]  held_flags;
    ref_div(a, b, er, ef, sp);
    wait_ready(tag);
    IN1 = a; IN2 = b; IN_VALID = 1'b1; OUT_READY = 1'b0;
    @(posedge CLK); #1;
    IN_VALID = 1'b0; IN1 = $urandom; IN2 = $urandom;
    lat = 0;
    while (!OUT_VALID && lat < 60) begin
      if (lat == 3) IN_VALID = 1'b1;
      @(posedge CLK); #1; lat++;
    end
    IN_VALID = 1'b0;
    check({tag, "_lat"}, 32'(lat), sp ? 32'd0 : 32'd26);
    check({tag, "_out"}, OUT, er);
    check({tag, "_flags"}, 32'(FLAGS), 32'(ef));
    held_out = OUT; held_flags = FLAGS;
    for (int i = 0; i < stall; i++) begin
      @(posedge CLK); #1;
      check({tag, "_hold"}, {OUT_VALID, IN_READY, FLAGS, OUT[24:0]},
            {1'b1, 1'b0, held_flags, held_out[24:0]});
      check({tag, "_holdhi"}, OUT, held_out);
    end
    OUT_READY = 1'b1; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0; IN_VALID = 1'b0;
    check({tag, "_handoff"}, {31'd0, OUT_VALID}, 32'd0);
    check({tag, "_noacc"}, 32'(IN_READY), 32'd1);
  endtask

  task automatic abort_op(input bit use_rst, input string tag);
    int seen;
    wait_ready(tag);
    IN1 = 32'h40C00000; IN2 = 32'h40000000; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (12) begin @(posedge CLK); #1; end
    if (use_rst) RST = 1'b1; else FLUSH = 1'b1;
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; FLUSH = 1'b0;
    check({tag, "_idle"}, {30'd0, IN_READY, OUT_VALID}, 32'd2);
    if (use_rst) check({tag, "_rstout"}, {OUT[26:0], FLAGS}, 32'd0);
    seen = 0;
    repeat (30) begin @(posedge CLK); #1; if (OUT_VALID) seen++; end
    OUT_READY = 1'b0;
    check({tag, "_novalid"}, 32'(seen), 32'd0);
    run_op(32'h3F800000, 32'h40400000, 0, {tag, "_next"});
  endtask

  initial begin
    RST = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    IN1 = 32'd0; IN2 = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_ready", 32'(IN_READY), 32'd1);
    check("reset_valid", 32'(OUT_VALID), 32'd0);
    check("reset_out", OUT, 32'd0);
    check("reset_flags", 32'(FLAGS), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    run_op(32'h40C00000, 32'h40000000, 0, "six_by_two");
    run_op(32'h3F800000, 32'h40400000, 0, "one_third");
    run_op(32'h3F800000, 32'h00000000, 0, "div_zero");
    run_op(32'h00000000, 32'h00000000, 0, "zero_zero");
    run_op(32'h7F000000, 32'h3E800000, 0, "overflow");
    run_op(32'h00800000, 32'h7F000000, 0, "underflow");
    run_op(32'h7F800000, 32'hFF800000, 0, "inf_inf");
    run_op(32'h7FC00001, 32'h7F800001, 0, "nan_a");
    run_op(32'h00123456, 32'h40000000, 0, "denorm_a");
    run_op(32'hC0C00000, 32'h40000000, 10, "stall10");

    abort_op(1'b0, "flush12");
    abort_op(1'b1, "rst12");

    for (int i = 0; i < 40; i++) begin
      run_op(rand_fp(), rand_fp(), $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
